// File: rtl/muldiv_sched.sv
// Iterative HI/LO multiply/divide sequencer: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_SIGNED_EN to add signed operation through a FIX state (sgn input honoured).
module muldiv_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_use,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             stall
);

  // state | meaning
  // IDLE  | waiting for start, HI/LO hold last result
  // CALC  | one multiply/divide iteration per cycle, WIDTH cycles
  // FIX   | sign correction of magnitude result (signed build only)
  // DONE  | HI/LO just committed, done pulse

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t state, state_n;

  logic [CW-1:0]    count;
  logic             op_r;
  logic             bz_r;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic             commit;
  logic [WIDTH-1:0] commit_hi;
  logic [WIDTH-1:0] commit_lo;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = CALC;
`ifdef MULDIV_SIGNED_EN
      CALC: if (count == '0) state_n = FIX;
      FIX:  state_n = DONE;
`else
      CALC: if (count == '0) state_n = DONE;
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign stall  = ~(busy & hilo_use);
  assign accept = (state == IDLE) & start;

`ifdef MULDIV_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;
  logic [2*WIDTH-1:0] prod_neg;

  assign a_mag = (sgn && a[WIDTH-1]) ? (-a) : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? (-b) : b;

  assign prod_neg = -{work_hi, work_lo};

  // With b==0 the quotient is left as all ones; re-signing the remainder restores hi=a.
  always_comb begin
    fin_hi = work_hi;
    fin_lo = work_lo;
    if (!op_r) begin
      if (neg_q) {fin_hi, fin_lo} = prod_neg;
    end else begin
      if (neg_q && !bz_r) fin_lo = -work_lo;
      if (neg_r)          fin_hi = -work_hi;
    end
  end

  assign commit    = (state == FIX);
  assign commit_hi = fin_hi;
  assign commit_lo = fin_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn & a[WIDTH-1];
    end
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;

  assign a_mag = a;
  assign b_mag = b;

  // Without the fix-up stage the final iteration's result is committed directly.
  assign commit    = (state == CALC) && (count == '0);
  assign commit_hi = step_hi;
  assign commit_lo = step_lo;
`endif

  always_comb begin
    mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh   = {work_hi, work_lo[WIDTH-1]};
    rem_diff = rem_sh[WIDTH-1:0] - opnd;
    step_hi  = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], work_lo[WIDTH-1:1]};
    if (op_r) begin
      if (rem_sh >= {1'b0, opnd}) begin
        step_hi = rem_diff;
        step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Multiply: opnd=multiplicand, work_lo=multiplier. Divide: opnd=divisor, work_lo=dividend.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      op_r    <= 1'b0;
      bz_r    <= 1'b0;
      opnd    <= '0;
      work_hi <= '0;
      work_lo <= '0;
      hi      <= '0;
      lo      <= '0;
      dz      <= 1'b0;
    end else begin
      if (accept) begin
        count   <= CW'(WIDTH - 1);
        op_r    <= op;
        bz_r    <= (b == '0);
        opnd    <= op ? b_mag : a_mag;
        work_hi <= '0;
        work_lo <= op ? a_mag : b_mag;
        dz      <= 1'b0;
      end else if (state == CALC) begin
        count   <= count - 1'b1;
        work_hi <= step_hi;
        work_lo <= step_lo;
      end
      if (commit) begin
        hi <= commit_hi;
        lo <= commit_lo;
        dz <= op_r & bz_r;
      end
    end
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Iterative multiply/divide sequencer owning the HI/LO register pair of the 5-stage MIPS pipeline. Accepts one MULT/DIV issue from EX, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, then commits HI/LO. While busy it drives the pipeline stall line, using the same convention as the hazard stall unit: stall=0 freezes, stall=1 runs. This keeps any HI/LO consumer in ID from advancing early.

## Interface
- WIDTH, 32, operand/result width; must be ≥2
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  EX-stage MULT/DIV valid, single-cycle pulse
- op  in  1  0 = multiply, 1 = divide
- sgn  in  1  signed operation request (see Configuration)
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- hilo_use  in  1  ID-stage instruction reads or writes HI/LO (MFHI, MFLO, MULT, DIV)
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse on the HI/LO commit cycle
- dz  out  1  last divide had b==0; cleared on next accepted start
- stall  out  1  0 = freeze pipeline, 1 = run

## Operation
- States: IDLE, CALC, FIX (present only with the macro), DONE.
- IDLE: start=1 captures a, b, op and sgn; loads count=WIDTH-1; next state is CALC; busy=1 from the next cycle. dz clears here.
- CALC, multiply: acc[2W-1:0] shift-add, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring. Shift {rem,quot} left by 1. If rem≥b, subtract b and set the quotient LSB to 1.
- CALC: the count decrements each cycle; on count==0 the next state is FIX if compiled in, else DONE.
- DONE: hi/lo are written and done=1 for 1 cycle; the next state is IDLE and busy=0.
- Divide by zero needs no special path. The natural result is lo={WIDTH{1}} and hi=a, and dz is set at DONE.
- hi/lo hold their previous values until DONE, so MFHI/MFLO before issue see the old result.
- start while busy is ignored: state and operands are unchanged, and no error is raised.
- stall = ~(busy & hilo_use). This is combinational and asserts in the same cycle hilo_use rises.
- start in the DONE cycle is ignored.
- Reset (async, any state): state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0, stall=1. An in-flight operation is discarded.

## Timing
- Start accepted at edge T0. CALC runs edges T1..T(WIDTH). DONE is the cycle after the last CALC edge.
- done/hi/lo are visible WIDTH+1 cycles after the start edge without the macro, and WIDTH+2 with it.
- The latency is fixed and independent of operand values.
- busy is high from T0+1 through the DONE cycle inclusive. stall=0 for every cycle where busy and hilo_use are both 1.
- A new start is accepted in the cycle after DONE (IDLE). The minimum issue interval is WIDTH+2 cycles, or WIDTH+3 with the macro.
- Output reset values: hi=0, lo=0, busy=0, done=0, dz=0, stall=1.

## Configuration
- MULDIV_SIGNED_EN defined:
  - When sgn=1, operands are converted to magnitudes at start.
  - FIX negates the product if a[W-1]^b[W-1].
  - For divide, FIX negates the quotient if a[W-1]^b[W-1], and the remainder takes the sign of a.
  - For b==0, FIX is a pass-through (hi=a, lo={WIDTH{1}}).
  - FIX is always traversed, including when sgn=0, so latency stays fixed.
- MULDIV_SIGNED_EN undefined: sgn is ignored, every operation is unsigned, and there is no FIX state.

## Test plan
- Multiply 7×6, WIDTH=32, unsigned: done at start+33 with hi=0x00000000, lo=0x0000002A; busy falls after done.
- Multiply 0xFFFFFFFF×0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- Divide 100/7: lo=14, hi=2, dz=0. Divide 5/0: lo=0xFFFFFFFF, hi=5, dz=1; the next start clears dz.
- Hold hilo_use=1 from start+1 to start+40 and pulse start again at start+5: stall=0 exactly while busy, then 1. The second start has no effect and the result matches the first operation.
- Assert reset at start+10: busy, done, hi and lo are 0 immediately; done never pulses for the aborted operation.
- With MULDIV_SIGNED_EN, sgn=1:
  - 0xFFFFFFF9×3 gives hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - 0xFFFFFFF9/2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Both complete at start+34.
  - Without the macro, the same multiply gives hi=0x00000002, lo=0xFFFFFFEB at start+33.
